// File: rtl/clkmon_pkg.sv
// Shared types and helpers for the system clock monitor: FSM states, count width,
// synchroniser depth and Gray/binary conversion.
package clkmon_pkg;

   localparam int CNT_W      = 16;
   localparam int SYNC_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RUN    = 2'd2,
      FAULT  = 2'd3
   } state_t;

   function automatic logic [CNT_W-1:0] bin2gray(input logic [CNT_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [CNT_W-1:0] gray2bin(input logic [CNT_W-1:0] gray);
      logic [CNT_W-1:0] bin;
      bin[CNT_W-1] = gray[CNT_W-1];
      for (int i = CNT_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/clkmon_gray_cdc.sv
// Monitored-clock edge counter with a registered Gray copy, carried into the
// board clock domain through a multi-flop synchroniser.
module clkmon_gray_cdc
   import clkmon_pkg::*;
(
   input  logic             brd_clk,
   input  logic             brd_rst,
   input  logic             mon_clk,
   output logic [CNT_W-1:0] gray_sync
);

   logic [SYNC_DEPTH-1:0] rst_pipe;
   logic                  mon_rst;
   logic [CNT_W-1:0]      bin_cnt;
   logic [CNT_W-1:0]      gray_q;
   logic [CNT_W-1:0]      sync_q [SYNC_DEPTH];

   // Reset asserts immediately but releases only on mon_clk edges.
   always_ff @(posedge mon_clk or posedge brd_rst) begin
      if (brd_rst) rst_pipe <= '1;
      else         rst_pipe <= {rst_pipe[SYNC_DEPTH-2:0], 1'b0};
   end

   assign mon_rst = rst_pipe[SYNC_DEPTH-1];

   // Gray register tracks the binary counter's next value so both step together.
   always_ff @(posedge mon_clk or posedge mon_rst) begin
      if (mon_rst) begin
         bin_cnt <= '0;
         gray_q  <= '0;
      end else begin
         bin_cnt <= bin_cnt + 1'b1;
         gray_q  <= bin2gray(bin_cnt + 1'b1);
      end
   end

   always_ff @(posedge brd_clk or posedge brd_rst) begin
      if (brd_rst) begin
         for (int i = 0; i < SYNC_DEPTH; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= gray_q;
         for (int i = 1; i < SYNC_DEPTH; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign gray_sync = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/sys_clk_monitor.sv
// Frequency/lock supervisor for the PLL system clock; raises o_rst_req unless in RUN.
// Optional min/max delta trackers built when SYS_CLK_MONITOR_MINMAX_EN is defined.
module sys_clk_monitor
   import clkmon_pkg::*;
#(
   parameter int P_WINDOW   = 1024,
   parameter int P_EXP_CNT  = 819,
   parameter int P_TOL      = 8,
   parameter int P_SETTLE   = 4,
   parameter int P_FAIL_LIM = 2,
   parameter int P_RST_HOLD = 4096
) (
   input  logic             i_brd_clk,
   input  logic             i_brd_rst,
   input  logic             i_mon_clk,
   input  logic             i_pll_locked,
   output logic             o_rst_req,
   output logic             o_freq_ok,
   output logic             o_clk_lost,
   output logic [CNT_W-1:0] o_meas,
   output logic             o_meas_valid,
   output logic [7:0]       o_fault_cnt,
   output logic [CNT_W-1:0] o_meas_min,
   output logic [CNT_W-1:0] o_meas_max
);

   localparam int WIN_W  = $clog2(P_WINDOW);
   localparam int HOLD_W = $clog2(P_RST_HOLD);
   localparam int SET_W  = $clog2(P_SETTLE + 1);
   localparam int FAIL_W = $clog2(P_FAIL_LIM + 1);

   // Absolute difference formed at CNT_W+1 bits so it cannot wrap.
   function automatic logic in_tol(input logic [CNT_W-1:0] d);
      logic signed [CNT_W:0] diff;
      diff = $signed({1'b0, d}) - $signed((CNT_W+1)'(P_EXP_CNT));
      if (diff < 0) diff = -diff;
      return diff <= $signed((CNT_W+1)'(P_TOL));
   endfunction

   logic [CNT_W-1:0]      gray_sync;
   logic [SYNC_DEPTH-1:0] lock_sync;
   logic                  lock_s;
   logic [WIN_W-1:0]      win_cnt;
   logic                  win_tc;
   logic [CNT_W-1:0]      sample_p0, prev_sample, delta;
   logic                  vld_p0;
   state_t                state_q, state_d;
   logic [SET_W-1:0]      settle_q, settle_d;
   logic [FAIL_W-1:0]     fail_q, fail_d;
   logic [HOLD_W-1:0]     hold_q, hold_d;
   logic                  fault_inc, run_entry;

   clkmon_gray_cdc u_gray_cdc (
      .brd_clk   (i_brd_clk),
      .brd_rst   (i_brd_rst),
      .mon_clk   (i_mon_clk),
      .gray_sync (gray_sync)
   );

   always_ff @(posedge i_brd_clk or posedge i_brd_rst) begin
      if (i_brd_rst) lock_sync <= '0;
      else           lock_sync <= {lock_sync[SYNC_DEPTH-2:0], i_pll_locked};
   end

   assign lock_s = lock_sync[SYNC_DEPTH-1];
   assign win_tc = (win_cnt == WIN_W'(P_WINDOW - 1));
   assign delta  = sample_p0 - prev_sample;

   // Stage p0: window terminal count captures the synced edge count.
   always_ff @(posedge i_brd_clk or posedge i_brd_rst) begin
      if (i_brd_rst) begin
         win_cnt   <= '0;
         vld_p0    <= 1'b0;
         sample_p0 <= '0;
      end else begin
         win_cnt <= win_tc ? '0 : win_cnt + 1'b1;
         vld_p0  <= win_tc;
         if (win_tc) sample_p0 <= gray2bin(gray_sync);
      end
   end

   // Stage p1: per-window delta and its classification.
   always_ff @(posedge i_brd_clk or posedge i_brd_rst) begin
      if (i_brd_rst) begin
         prev_sample  <= '0;
         o_meas       <= '0;
         o_freq_ok    <= 1'b0;
         o_clk_lost   <= 1'b0;
         o_meas_valid <= 1'b0;
      end else begin
         o_meas_valid <= vld_p0;
         if (vld_p0) begin
            o_meas      <= delta;
            prev_sample <= sample_p0;
            o_freq_ok   <= in_tol(delta);
            o_clk_lost  <= (delta == '0);
         end
      end
   end

   always_ff @(posedge i_brd_clk or posedge i_brd_rst) begin
      if (i_brd_rst) begin
         state_q     <= IDLE;
         settle_q    <= '0;
         fail_q      <= '0;
         hold_q      <= '0;
         o_fault_cnt <= '0;
         o_rst_req   <= 1'b1;
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         fail_q    <= fail_d;
         hold_q    <= hold_d;
         o_rst_req <= (state_q != RUN);
         if (fault_inc && o_fault_cnt != 8'hFF) o_fault_cnt <= o_fault_cnt + 8'd1;
      end
   end

   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      fail_d    = fail_q;
      hold_d    = hold_q;
      fault_inc = 1'b0;
      run_entry = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (lock_s) begin
               state_d  = SETTLE;
               settle_d = '0;
            end
         end
         SETTLE: begin
            if (!lock_s) begin
               state_d = IDLE;
            end else if (o_meas_valid) begin
               if (!o_freq_ok) begin
                  settle_d = '0;
               end else if (settle_q == SET_W'(P_SETTLE - 1)) begin
                  state_d   = RUN;
                  fail_d    = '0;
                  run_entry = 1'b1;
               end else begin
                  settle_d = settle_q + 1'b1;
               end
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_d = IDLE;
            end else if (o_meas_valid) begin
               if (o_freq_ok) begin
                  fail_d = '0;
               end else if (fail_q == FAIL_W'(P_FAIL_LIM - 1)) begin
                  state_d   = FAULT;
                  hold_d    = '0;
                  fault_inc = 1'b1;
               end else begin
                  fail_d = fail_q + 1'b1;
               end
            end
         end
         FAULT: begin
            if (hold_q == HOLD_W'(P_RST_HOLD - 1)) state_d = IDLE;
            else                                  hold_d  = hold_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef SYS_CLK_MONITOR_MINMAX_EN
   logic [CNT_W-1:0] min_q, max_q;

   always_ff @(posedge i_brd_clk or posedge i_brd_rst) begin
      if (i_brd_rst) begin
         min_q <= '1;
         max_q <= '0;
      end else if (run_entry) begin
         min_q <= '1;
         max_q <= '0;
      end else if (state_q == RUN && o_meas_valid) begin
         if (o_meas < min_q) min_q <= o_meas;
         if (o_meas > max_q) max_q <= o_meas;
      end
   end

   assign o_meas_min = min_q;
   assign o_meas_max = max_q;
`else
   assign o_meas_min = '1;
   assign o_meas_max = '0;
`endif

endmodule

// File: tb/tb_sys_clk_monitor.sv
// Directed-sequence bench for sys_clk_monitor with randomized clock ratios and a
// ratio-based reference for the expected per-window edge count.
module tb_sys_clk_monitor;

   localparam int BRD_HALF = 1000;
   localparam int EXP_CNT  = 819;
   localparam int TOL      = 8;

   logic        brd_clk = 1'b0;
   logic        mon_clk = 1'b0;
   logic        brd_rst = 1'b1;
   logic        pll_locked = 1'b0;
   logic        rst_req, freq_ok, clk_lost, meas_valid;
   logic [15:0] meas, meas_min, meas_max;
   logic [7:0]  fault_cnt;

   int          mon_half = 1250;
   bit          mon_run = 1'b1;
   int unsigned mon_edges;
   int          ncmp = 0;
   int          nfail = 0;

   sys_clk_monitor dut (
      .i_brd_clk    (brd_clk),
      .i_brd_rst    (brd_rst),
      .i_mon_clk    (mon_clk),
      .i_pll_locked (pll_locked),
      .o_rst_req    (rst_req),
      .o_freq_ok    (freq_ok),
      .o_clk_lost   (clk_lost),
      .o_meas       (meas),
      .o_meas_valid (meas_valid),
      .o_fault_cnt  (fault_cnt),
      .o_meas_min   (meas_min),
      .o_meas_max   (meas_max)
   );

   always #(BRD_HALF) brd_clk = ~brd_clk;

   initial begin
      forever begin
         #(mon_half);
         if (mon_run) mon_clk = ~mon_clk;
      end
   end

   always @(posedge mon_clk or posedge brd_rst) begin
      if (brd_rst) mon_edges <= 0;
      else         mon_edges <= mon_edges + 1;
   end

   initial begin
      #(64'd400000000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected monitored edges in one 1024-cycle board window, from the clock ratio.
   function automatic real pred_delta(input int half);
      return 1024.0 * real'(BRD_HALF) / real'(half);
   endfunction

   function automatic int good_half();
      return int'($urandom_range(1257, 1243));
   endfunction

   function automatic int bad_half();
      return int'($urandom_range(1225, 1200));
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_near(input string tag, input logic [15:0] obs, input int half);
      real p, d;
      p = pred_delta(half);
      d = real'(obs) - p;
      if (d < 0.0) d = -d;
      ncmp++;
      assert (d <= 2.0 && !$isunknown(obs)) else begin
         nfail++;
         $error("FAIL %s: observed %0d, expected %0d +/- 2", tag, obs, $rtoi(p + 0.5));
      end
   endtask

   task automatic wait_pulse(output int n);
      n = 0;
      do begin
         @(negedge brd_clk);
         n++;
      end while (meas_valid !== 1'b1 && n < 1100);
      ncmp++;
      assert (meas_valid === 1'b1) else begin
         nfail++;
         $error("FAIL pulse_timeout: observed no o_meas_valid in %0d cycles, expected one", n);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rst_req"},   rst_req,    1);
      check({tag, "_freq_ok"},   freq_ok,    0);
      check({tag, "_clk_lost"},  clk_lost,   0);
      check({tag, "_meas"},      meas,       0);
      check({tag, "_valid"},     meas_valid, 0);
      check({tag, "_fault_cnt"}, fault_cnt,  0);
      check({tag, "_min"},       meas_min,   16'hFFFF);
      check({tag, "_max"},       meas_max,   0);
   endtask

   initial begin
      int n, h, pulses;

      // Reset with lock already high.
      pll_locked = 1'b1;
      mon_half   = good_half();
      h          = mon_half;
      repeat (5) @(negedge brd_clk);
      check_reset_values("init");
      brd_rst = 1'b0;

      // Nominal: first window discarded, then P_SETTLE good windows reach RUN.
      wait_pulse(n);
      wait_pulse(n);
      check_near("nom_meas2", meas, h);
      wait_pulse(n);
      check_near("nom_meas3", meas, h);
      @(negedge brd_clk);
      check("nom_valid_one_cycle", meas_valid, 0);
      repeat (2) @(negedge brd_clk);
      check("nom_rst_req_settle", rst_req, 1);
      wait_pulse(n);
      wait_pulse(n);
      check_near("nom_meas5", meas, h);
      check("nom_freq_ok", freq_ok, 1);
      check("nom_clk_lost", clk_lost, 0);
      repeat (3) @(negedge brd_clk);
      check("nom_rst_req_run", rst_req, 0);
      wait_pulse(n);
      wait_pulse(n);
      check("nom_period", n, 1024);
      check_near("nom_meas7", meas, h);
      repeat (3) @(negedge brd_clk);
`ifdef SYS_CLK_MONITOR_MINMAX_EN
      check("minmax_lo", (meas_min <= meas), 1);
      check("minmax_hi", (meas_max >= meas), 1);
      check("minmax_order", (meas_min <= meas_max), 1);
`else
      check("min_const", meas_min, 16'hFFFF);
      check("max_const", meas_max, 0);
`endif

      // Clock stop in RUN.
      wait_pulse(n);
      mon_run = 1'b0;
      wait_pulse(n);
      wait_pulse(n);
      check("stop_clk_lost", clk_lost, 1);
      check("stop_freq_ok", freq_ok, 0);
      check("stop_meas", meas, 0);
      repeat (3) @(negedge brd_clk);
      check("stop_rst_req", rst_req, 1);
      check("stop_fault_cnt", fault_cnt, 1);
      mon_half = good_half();
      h        = mon_half;
      mon_run  = 1'b1;
      pulses   = 0;
      do begin
         wait_pulse(n);
         repeat (3) @(negedge brd_clk);
         pulses++;
      end while (rst_req !== 1'b0 && pulses < 12);
      check("stop_recover_run", rst_req, 0);
      check("stop_fault_dwell", (pulses >= 8), 1);
      check("stop_fault_cnt_hold", fault_cnt, 1);

      // Off-frequency in RUN drives FAULT.
      mon_half = bad_half();
      h        = mon_half;
      wait_pulse(n);
      wait_pulse(n);
      check_near("offf_meas", meas, h);
      check("offf_freq_ok", freq_ok, 0);
      wait_pulse(n);
      repeat (3) @(negedge brd_clk);
      check("offf_rst_req", rst_req, 1);
      check("offf_fault_cnt", fault_cnt, 2);

      // Slightly fast but in tolerance: recovers and stays in RUN.
      mon_half = 1241;
      pulses   = 0;
      do begin
         wait_pulse(n);
         repeat (3) @(negedge brd_clk);
         pulses++;
      end while (rst_req !== 1'b0 && pulses < 14);
      check("near_recover_run", rst_req, 0);
      for (int k = 0; k < 3; k++) begin
         wait_pulse(n);
         check_near("near_meas", meas, 1241);
         check("near_freq_ok", freq_ok, 1);
         repeat (3) @(negedge brd_clk);
         check("near_rst_req", rst_req, 0);
      end

      // Lock loss coinciding with a measurement pulse.
      wait_pulse(n);
      repeat (1022) @(negedge brd_clk);
      pll_locked = 1'b0;
      wait_pulse(n);
      repeat (3) @(negedge brd_clk);
      check("lock_rst_req", rst_req, 1);
      check("lock_fault_cnt", fault_cnt, 2);
      pll_locked = 1'b1;

      // Asynchronous reset between clock edges.
      repeat (300) @(negedge brd_clk);
      #(BRD_HALF / 2);
      brd_rst = 1'b1;
      #10;
      check_reset_values("midrst");
      repeat (3) @(negedge brd_clk);
      brd_rst = 1'b0;

      // Run the monitored counter up to its wrap point, then measure across it.
      mon_half = 100;
      n = 0;
      while (mon_edges < 65536 - 2600 && n < 10000) begin
         @(negedge brd_clk);
         n++;
      end
      mon_half = good_half();
      h        = mon_half;
      wait_pulse(n);
      wait_pulse(n);
      for (int k = 0; k < 5; k++) begin
         wait_pulse(n);
         check_near("wrap_meas", meas, h);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/sys_clk_monitor.md
# sys_clk_monitor

Supervises the PLL-derived system clock from the board crystal domain. It counts edges of a monitored clock (o_sys_clk of the clock/reset stage) over fixed windows of i_brd_clk and checks each count against an expected value. A lock-qualified state machine raises a system reset request when the clock is missing, off-frequency or unlocked. It sits beside the clock/reset stage and consumes its PLL outputs; o_rst_req is ORed into the system reset tree.

## Interface
- P_WINDOW, 1024: gate window length in i_brd_clk cycles.
- P_EXP_CNT, 819: expected monitored-clock edges per window.
- P_TOL, 8: allowed |count − P_EXP_CNT|, inclusive.
- P_SETTLE, 4: consecutive good windows needed to leave SETTLE.
- P_FAIL_LIM, 2: consecutive bad windows in RUN that trigger FAULT.
- P_RST_HOLD, 4096: FAULT dwell in i_brd_clk cycles.
- i_brd_clk  in  1  board crystal clock, measurement reference.
- i_brd_rst  in  1  reset i_brd_rst, asynchronous, active-high; clock i_brd_clk.
- i_mon_clk  in  1  monitored clock.
- i_pll_locked  in  1  PLL lock, asynchronous to i_brd_clk.
- o_rst_req  out  1  system reset request; reset value 1.
- o_freq_ok  out  1  last window within tolerance; reset value 0.
- o_clk_lost  out  1  last window counted zero edges; reset value 0.
- o_meas  out  16  last window edge count; reset value 0.
- o_meas_valid  out  1  one-cycle pulse when o_meas updates; reset value 0.
- o_fault_cnt  out  8  saturating count of FAULT entries; reset value 0.
- o_meas_min  out  16  minimum count seen in RUN; reset value 0xFFFF.
- o_meas_max  out  16  maximum count seen in RUN; reset value 0.

## Operation
- **Edge counter (mon domain):**
  - 16-bit binary counter with a registered Gray copy.
  - Reset asserts asynchronously from i_brd_rst. Reset release is synchronised by 2 flops in i_mon_clk.
- **Crossing to brd domain:**
  - Gray value passes through a 2-flop synchroniser into i_brd_clk.
  - i_pll_locked uses its own 2-flop synchroniser, giving lock_s.
- **Window and count:**
  - Window counter runs 0..P_WINDOW−1 continuously from reset, in every state.
  - At terminal count (cycle N), the synced Gray value is converted to binary and stored in a sample register.
  - Cycle N+1: o_meas <= sample − prev_sample (modulo 2^16), then prev_sample <= sample, and o_meas_valid pulses.
  - o_freq_ok and o_clk_lost update in the same cycle as o_meas.
- **Window classification:** a window is good when |delta − P_EXP_CNT| ≤ P_TOL.
- **Width rules:**
  - P_EXP_CNT + P_TOL must be < 2^15.
  - The absolute difference is computed at 17 bits, then compared.
- **FSM states:** IDLE, SETTLE, RUN, FAULT. Reset state is IDLE.
  - IDLE: when lock_s=1, go to SETTLE and clear the settle counter.
  - SETTLE: each good window increments the settle counter; a bad window clears it. When the counter reaches P_SETTLE, go to RUN.
  - RUN: each bad window increments the fail counter; a good window clears it. When the counter reaches P_FAIL_LIM, go to FAULT and increment o_fault_cnt (saturating at 255).
  - FAULT: hold for P_RST_HOLD cycles, then go to IDLE. Lock changes are ignored during FAULT.
- **Lock loss:** lock_s=0 in SETTLE or RUN sends the FSM to IDLE on the next cycle. This is not a fault. Lock loss wins over a simultaneous o_meas_valid.
- **Reset request:** o_rst_req = 1 in IDLE, SETTLE and FAULT; 0 only in RUN. It is registered from the state.
- **Reset mid-operation:** i_brd_rst returns all registers to their reset values immediately. The first window after reset produces a discardable count, because prev_sample = 0; it always falls in SETTLE/IDLE.

## Timing
- Lock to SETTLE: 3 cycles (2 sync flops + FSM register).
- Monitored-clock edge to visibility in the brd domain: 2 mon + 2 brd cycles.
- Sample uncertainty: ±2 counts per window, which P_TOL must cover.
- o_meas_valid: exactly 1 cycle every P_WINDOW cycles, at window-counter cycle 0.
- Bad window to o_rst_req=1 in RUN:
  - P_FAIL_LIM windows to the FAULT transition.
  - +1 cycle for the o_rst_req register.
- Minimum reset pulse on fault: P_RST_HOLD + (P_SETTLE+1)·P_WINDOW cycles.

## Configuration
- **SYS_CLK_MONITOR_MINMAX_EN defined:**
  - o_meas_min and o_meas_max track extreme delta values from windows classified in RUN.
  - They clear to 0xFFFF and 0 on each entry to RUN.
- **Not defined:** the trackers are not built; o_meas_min = 0xFFFF and o_meas_max = 0 constantly.

## Structure
- **Package clkmon_pkg holds:**
  - the state enum (IDLE/SETTLE/RUN/FAULT)
  - the count width (16)
  - the sync depth (2)
  - the gray2bin/bin2gray functions
- **Sub-module clkmon_gray_cdc:**
  - mon-domain reset synchroniser
  - edge counter with Gray register
  - 2-flop brd-domain capture
  - output is the synced Gray value.

## Test plan
- **Nominal:** brd 50 MHz, mon 40 MHz, lock high from t=0 → delta 817..821 each window; RUN after 5 valid pulses (one discarded plus P_SETTLE=4 good); o_rst_req falls 1 cycle after RUN.
- **Clock stop:** in RUN, stop i_mon_clk → o_clk_lost=1 and o_freq_ok=0 on the next pulse; FAULT after 2 windows; o_rst_req=1; o_fault_cnt=1; IDLE after 4096 cycles.
- **Off-frequency:** mon at 41 MHz → delta ≈ 840; bad windows → FAULT. At 40.3 MHz → delta ≈ 825 → stays RUN.
- **Lock drop in RUN:** lock low coinciding with o_meas_valid → IDLE within 3 cycles; o_fault_cnt unchanged; o_rst_req=1.
- **Wrap-around:** run long enough for the mon counter to wrap past 0xFFFF → delta stays 819±2 across the wrap.
- **Async reset mid-window:** all outputs at reset values within 1 cycle, with no X.
- **With SYS_CLK_MONITOR_MINMAX_EN:** min/max bracket the observed deltas.
